bus_memory_responder: RTL and testbench

BUS_MEMORY_RESPONDER -- requirements
Module: bus_memory_responder

---
 rtl/bus_memory_responder_if.sv | 41 ++++
 rtl/bus_memory_responder.sv | 187 ++++++++++++++++++
 tb/tb_bus_memory_responder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_memory_responder_if.sv
//==============================================================================
// Module     : bus_memory_responder_if
// Description: Shared-bus signal bundle between a bus initiator and the
//              memory responder. Signals suffixed IN are driven by the
//              initiator; signals suffixed OUT are driven by the responder.
// Modports   : master - initiator side, slave - responder side
// Revision   : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface bus_memory_responder_if;
    logic [31:0] address_dataIN;
    logic [3:0]  byte_enableIN;
    logic [7:0]  burst_sizeIN;
    logic        read_n_writeIN;
    logic        begin_transactionIN;
    logic        end_transactionIN;
    logic        data_validIN;
    logic        busyIN;

    logic [31:0] address_dataOUT;
    logic        end_transactionOUT;
    logic        data_validOUT;
    logic        busyOUT;
    logic        errorOUT;

    modport master (
        output address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
        output begin_transactionIN, end_transactionIN, data_validIN, busyIN,
        input  address_dataOUT, end_transactionOUT, data_validOUT, busyOUT, errorOUT
    );

    modport slave (
        input  address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
        input  begin_transactionIN, end_transactionIN, data_validIN, busyIN,
        output address_dataOUT, end_transactionOUT, data_validOUT, busyOUT, errorOUT
    );
endinterface

`default_nettype wire

// File: rtl/bus_memory_responder.sv
//==============================================================================
// Module     : bus_memory_responder
// Description: Burst-capable 32-bit memory responder on a multiplexed
//              address/data bus. A begin whose upper address bits match the
//              window base opens a write or read burst into a local memory
//              of 2**WORDS_LOG2 words. Read data is returned with initiator
//              backpressure (busyIN) and closed with a one-cycle end pulse.
// Ports      : system_clock - single clock, rising edge
//              reset        - synchronous, active high
//              bus          - slave modport of bus_memory_responder_if
// Parameters : BASE_ADDRESS - window base, aligned to the window size
//              WORDS_LOG2   - log2 of the number of memory words
// Options    : BUS_RESPONDER_ERROR_EN - when defined, a hit begin with a
//              misaligned address is answered with errorOUT plus an end
//              pulse and performs no memory access.
// Revision   : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module bus_memory_responder #(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int          WORDS_LOG2   = 8
) (
    input  logic                   system_clock,
    input  logic                   reset,
    bus_memory_responder_if.slave  bus
);

    localparam int DEPTH   = 1 << WORDS_LOG2;
    localparam int TAG_LSB = WORDS_LOG2 + 2;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WRITE  = 2'd1;
    localparam logic [1:0] READ   = 2'd2;
    localparam logic [1:0] ENDING = 2'd3;

    logic [1:0]            state;
    logic [1:0]            next_state;

    logic [31:0]           mem [DEPTH];
    logic [WORDS_LOG2-1:0] word_idx;
    logic [3:0]            byte_en;
    // Beats still owed in this burst (burst_size + 1 at begin, so 1..256).
    logic [8:0]            beats_left;
    logic                  rd_valid;
    logic [31:0]           rd_data;

    logic                  hit;
    logic                  begin_hit;
    logic                  addr_err;
    logic                  write_beat;
    logic                  read_fetch;
    logic                  read_accept;
    logic                  read_last;

    assign hit       = (bus.address_dataIN[31:TAG_LSB] == BASE_ADDRESS[31:TAG_LSB]);
    assign begin_hit = (state == IDLE) && bus.begin_transactionIN && hit;

`ifdef BUS_RESPONDER_ERROR_EN
    logic err_flag;
    assign addr_err = (bus.address_dataIN[1:0] != 2'b00);
`else
    assign addr_err = 1'b0;
`endif

    // Beats past the latched burst length arrive with beats_left == 0
    // and are dropped.
    assign write_beat  = (state == WRITE) && bus.data_validIN && (beats_left != 9'd0);
    // An incoming end aborts a read, so it overrides fetch and accept.
    assign read_fetch  = (state == READ) && !rd_valid && !bus.end_transactionIN;
    assign read_accept = (state == READ) && rd_valid && !bus.busyIN && !bus.end_transactionIN;
    assign read_last   = (beats_left == 9'd1);

    // State register
    always_ff @(posedge system_clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (begin_hit) begin
                    if (addr_err)                next_state = ENDING;
                    else if (bus.read_n_writeIN) next_state = READ;
                    else                         next_state = WRITE;
                end
            end
            WRITE: begin
                if (bus.end_transactionIN) next_state = IDLE;
            end
            READ: begin
                if (bus.end_transactionIN)           next_state = IDLE;
                else if (read_accept && read_last)   next_state = ENDING;
            end
            ENDING: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode; data is forced to 0 when not valid so the
    // wired-OR bus sees nothing from this responder.
    always_comb begin
        bus.end_transactionOUT = (state == ENDING);
        bus.data_validOUT      = (state == READ) && rd_valid;
        bus.address_dataOUT    = 32'h0000_0000;
        bus.busyOUT            = 1'b0;
        if (bus.data_validOUT) begin
            bus.address_dataOUT = rd_data;
        end
    end

`ifdef BUS_RESPONDER_ERROR_EN
    assign bus.errorOUT = (state == ENDING) && err_flag;
`else
    assign bus.errorOUT = 1'b0;
`endif

    // Burst bookkeeping and read pipeline. word_idx always names the next
    // word to fetch or write; its width gives the modulo wrap for free.
    always_ff @(posedge system_clock) begin
        if (reset) begin
            word_idx   <= '0;
            byte_en    <= 4'h0;
            beats_left <= 9'd0;
            rd_valid   <= 1'b0;
            rd_data    <= 32'h0000_0000;
`ifdef BUS_RESPONDER_ERROR_EN
            err_flag   <= 1'b0;
`endif
        end else begin
            if (begin_hit) begin
                word_idx   <= bus.address_dataIN[TAG_LSB-1:2];
                byte_en    <= bus.byte_enableIN;
                beats_left <= {1'b0, bus.burst_sizeIN} + 9'd1;
                rd_valid   <= 1'b0;
`ifdef BUS_RESPONDER_ERROR_EN
                err_flag   <= addr_err;
`endif
            end

            if (write_beat) begin
                word_idx   <= word_idx + 1'b1;
                beats_left <= beats_left - 9'd1;
            end

            if (read_fetch || (read_accept && !read_last)) begin
                rd_data  <= mem[word_idx];
                word_idx <= word_idx + 1'b1;
                rd_valid <= 1'b1;
            end

            if (read_accept) begin
                beats_left <= beats_left - 9'd1;
                if (read_last) rd_valid <= 1'b0;
            end

            if ((state == READ) && bus.end_transactionIN) begin
                rd_valid <= 1'b0;
            end
        end
    end

    // Memory array: byte-masked writes, contents survive reset.
    always_ff @(posedge system_clock) begin
        if (!reset && write_beat) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][b*8 +: 8] <= bus.address_dataIN[b*8 +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_memory_responder.sv
//==============================================================================
// Module     : tb_bus_memory_responder
// Description: Self-checking bench for bus_memory_responder. Read data is
//              scored against a queue of expected words filled from a
//              reference memory image when each read burst is issued.
// Revision   : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bus_memory_responder;

    localparam logic [31:0] BASE = 32'h0001_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_memory_responder_if bus();

    bus_memory_responder #(
        .BASE_ADDRESS (BASE),
        .WORDS_LOG2   (8)
    ) dut (
        .system_clock (clk),
        .reset        (rst),
        .bus          (bus)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] model_mem [256];
    logic [31:0] sb [$];
    logic [31:0] wdata [8];
    bit          mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle;
        bus.address_dataIN      = 32'h0;
        bus.byte_enableIN       = 4'h0;
        bus.burst_sizeIN        = 8'h0;
        bus.read_n_writeIN      = 1'b0;
        bus.begin_transactionIN = 1'b0;
        bus.end_transactionIN   = 1'b0;
        bus.data_validIN        = 1'b0;
        bus.busyIN              = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 32'(bus.data_validOUT), 32'd0);
        check({tag, "_end"},   32'(bus.end_transactionOUT), 32'd0);
        check({tag, "_err"},   32'(bus.errorOUT), 32'd0);
        check({tag, "_busy"},  32'(bus.busyOUT), 32'd0);
        check({tag, "_data"},  bus.address_dataOUT, 32'd0);
    endtask

    // Scoreboard consumer: a beat is taken whenever it is presented and
    // not held off by busyIN. Idle bus must read as zero.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.data_validOUT === 1'b1 && bus.busyIN === 1'b0) begin
                check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) check("read_data", bus.address_dataOUT, sb.pop_front());
            end
            if (bus.data_validOUT !== 1'b1) check("idle_bus_zero", bus.address_dataOUT, 32'd0);
        end
    end

    // Writes nbeats words from wdata; only the first burst+1 land in memory
    // when 'lands' is set (hit and well-formed).
    task automatic write_burst(input logic [31:0] addr, input logic [3:0] be,
                               input int burst, input int nbeats, input bit lands);
        logic [7:0] w;
        bus.address_dataIN      = addr;
        bus.byte_enableIN       = be;
        bus.burst_sizeIN        = burst[7:0];
        bus.read_n_writeIN      = 1'b0;
        bus.begin_transactionIN = 1'b1;
        tick;
        bus.begin_transactionIN = 1'b0;
        bus.byte_enableIN       = 4'h0;
        bus.burst_sizeIN        = 8'h0;
        check("write_no_error", 32'(bus.errorOUT), 32'd0);
        for (int i = 0; i < nbeats; i++) begin
            bus.address_dataIN    = wdata[i];
            bus.data_validIN      = 1'b1;
            bus.end_transactionIN = (i == nbeats - 1);
            if (lands && i <= burst) begin
                w = addr[9:2] + i[7:0];
                for (int b = 0; b < 4; b++)
                    if (be[b]) model_mem[w][b*8 +: 8] = wdata[i][b*8 +: 8];
            end
            check("write_busy_low", 32'(bus.busyOUT), 32'd0);
            tick;
        end
        bus_idle;
        tick;
    endtask

    task automatic read_burst(input logic [31:0] addr, input int burst, input int busy_cycles);
        logic [7:0] w;
        int         cycles;
        for (int i = 0; i <= burst; i++) begin
            w = addr[9:2] + i[7:0];
            sb.push_back(model_mem[w]);
        end
        bus.address_dataIN      = addr;
        bus.burst_sizeIN        = burst[7:0];
        bus.read_n_writeIN      = 1'b1;
        bus.begin_transactionIN = 1'b1;
        tick;
        bus_idle;
        check("rd_lat_b1_valid", 32'(bus.data_validOUT), 32'd0);
        tick;
        check("rd_lat_b2_valid", 32'(bus.data_validOUT), 32'd1);
        check("rd_beat0_data", bus.address_dataOUT, model_mem[addr[9:2]]);
        bus.busyIN = 1'b1;
        for (int k = 0; k < busy_cycles; k++) begin
            tick;
            check("busy_hold_valid", 32'(bus.data_validOUT), 32'd1);
            check("busy_hold_data", bus.address_dataOUT, model_mem[addr[9:2]]);
        end
        bus.busyIN = 1'b0;
        cycles = 0;
        while (bus.end_transactionOUT !== 1'b1 && cycles < burst + 8) begin
            tick;
            cycles++;
        end
        check("end_latency", 32'(cycles), 32'(burst + 1));
        check("end_valid_low", 32'(bus.data_validOUT), 32'd0);
        check("end_no_error", 32'(bus.errorOUT), 32'd0);
        tick;
        check("end_single_pulse", 32'(bus.end_transactionOUT), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
        rst = 1'b1;
        bus_idle;
        repeat (3) tick;
        check_outputs_zero("reset");
        rst = 1'b0;
        mon_en = 1'b1;
        tick;

        // Four-beat write then read back
        wdata[0] = 32'd1; wdata[1] = 32'd2; wdata[2] = 32'd3; wdata[3] = 32'd4;
        write_burst(BASE + 32'h10, 4'hF, 3, 4, 1'b1);
        read_burst(BASE + 32'h10, 3, 0);

        // Byte-enable merge
        wdata[0] = 32'h1122_3344;
        write_burst(BASE + 32'h30, 4'hF, 0, 1, 1'b1);
        wdata[0] = 32'hAABB_CCDD;
        write_burst(BASE + 32'h30, 4'b0101, 0, 1, 1'b1);
        read_burst(BASE + 32'h30, 0, 0);

        // Extra write beat beyond the burst length is discarded
        wdata[0] = 32'hA5A5_0001; wdata[1] = 32'hDEAD_BEEF;
        write_burst(BASE + 32'h18, 4'hF, 0, 2, 1'b1);
        read_burst(BASE + 32'h18, 1, 0);

        // Backpressure on beat 0
        read_burst(BASE + 32'h10, 1, 3);

        // Wrap from last word to word 0
        wdata[0] = 32'hCAFE_0255; wdata[1] = 32'hCAFE_0000;
        write_burst(BASE + 32'h3FC, 4'hF, 1, 2, 1'b1);
        read_burst(BASE + 32'h3FC, 1, 0);

        // Non-hit write and read are ignored
        wdata[0] = 32'hBAD0_0001;
        write_burst(BASE + 32'h410, 4'hF, 0, 1, 1'b0);
        bus.address_dataIN      = BASE + 32'h410;
        bus.read_n_writeIN      = 1'b1;
        bus.begin_transactionIN = 1'b1;
        tick;
        bus_idle;
        for (int k = 0; k < 3; k++) begin
            tick;
            check("miss_no_valid", 32'(bus.data_validOUT), 32'd0);
            check("miss_no_end", 32'(bus.end_transactionOUT), 32'd0);
        end
        read_burst(BASE + 32'h10, 0, 0);

        // Abort of a read burst by end_transactionIN mid-burst
        sb.push_back(model_mem[4]);
        bus.address_dataIN      = BASE + 32'h10;
        bus.burst_sizeIN        = 8'd3;
        bus.read_n_writeIN      = 1'b1;
        bus.begin_transactionIN = 1'b1;
        tick;
        bus_idle;
        tick;
        tick;
        bus.busyIN            = 1'b1;
        bus.end_transactionIN = 1'b1;
        tick;
        bus_idle;
        check("abort_valid_low", 32'(bus.data_validOUT), 32'd0);
        check("abort_no_end", 32'(bus.end_transactionOUT), 32'd0);
        tick;
        check("abort_no_end_later", 32'(bus.end_transactionOUT), 32'd0);
        check("abort_sb_drained", 32'(sb.size()), 32'd0);

        // Reset during beat 2 of a 4-beat read
        sb.push_back(model_mem[4]); sb.push_back(model_mem[5]); sb.push_back(model_mem[6]);
        bus.address_dataIN      = BASE + 32'h10;
        bus.burst_sizeIN        = 8'd3;
        bus.read_n_writeIN      = 1'b1;
        bus.begin_transactionIN = 1'b1;
        tick;
        bus_idle;
        tick;
        tick;
        tick;
        rst = 1'b1;
        tick;
        check_outputs_zero("rst_mid_read");
        check("rst_sb_drained", 32'(sb.size()), 32'd0);
        rst = 1'b0;
        tick;
        read_burst(BASE + 32'h10, 3, 0);

`ifdef BUS_RESPONDER_ERROR_EN
        // Misaligned begin is rejected with an error pulse
        bus.address_dataIN      = BASE + 32'h02;
        bus.byte_enableIN       = 4'hF;
        bus.read_n_writeIN      = 1'b0;
        bus.begin_transactionIN = 1'b1;
        tick;
        bus.begin_transactionIN = 1'b0;
        bus.address_dataIN      = 32'h5555_5555;
        bus.data_validIN        = 1'b1;
        check("err_pulse_err", 32'(bus.errorOUT), 32'd1);
        check("err_pulse_end", 32'(bus.end_transactionOUT), 32'd1);
        tick;
        bus_idle;
        check("err_clear_err", 32'(bus.errorOUT), 32'd0);
        check("err_clear_end", 32'(bus.end_transactionOUT), 32'd0);
        tick;
        read_burst(BASE, 0, 0);
`else
        // Low address bits are ignored: BASE+2 addresses word 0
        wdata[0] = 32'h0123_4567;
        write_burst(BASE + 32'h02, 4'hF, 0, 1, 1'b1);
        read_burst(BASE, 0, 0);
`endif

        tick;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
